// File: rtl/add_sub_seq.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands processed CHUNK bits per clock with a registered carry chain.
// Optional carry-in port enabled by defining ADD_SUB_SEQ_CIN_EN.
module add_sub_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
`ifdef ADD_SUB_SEQ_CIN_EN
  input  logic             cin,
`endif
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             C,
  output logic             V,
  output logic             N,
  output logic             Z
);

  localparam int unsigned NCH = WIDTH / CHUNK;
  localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned CW1 = CHUNK + 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             zacc_q, zacc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             v_q, v_d;
  logic             n_q, n_d;
  logic             z_q, z_d;

  logic [31:0]      base;
  logic [CHUNK-1:0] a_sl, b_sl, s_sl;
  logic             c_out;
  logic             cin0;

`ifdef ADD_SUB_SEQ_CIN_EN
  assign cin0 = cin;
`else
  assign cin0 = op;
`endif

  // One CHUNK-bit slice of the datapath, selected by the slice counter
  always_comb begin
    base = 32'(cnt_q) * CHUNK;
    a_sl = a_q[base +: CHUNK];
    b_sl = b_q[base +: CHUNK];
    {c_out, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + CW1'(carry_q);
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    zacc_d  = zacc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    c_d     = c_q;
    v_d     = v_q;
    n_d     = n_q;
    z_d     = z_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (start) begin
          a_d     = a;
          b_d     = op ? ~b : b;
          carry_d = cin0;
          cnt_d   = '0;
          zacc_d  = 1'b1;
          busy_d  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        res_d[base +: CHUNK] = s_sl;
        carry_d = c_out;
        zacc_d  = zacc_q & ~(|s_sl);
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // The final slice is folded straight into sum and the flags
          sum_d   = res_d;
          c_d     = c_out;
          n_d     = s_sl[CHUNK-1];
          z_d     = zacc_q & ~(|s_sl);
          v_d     = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_sl[CHUNK-1] != a_q[WIDTH-1]);
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      zacc_q  <= zacc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      v_q     <= v_d;
      n_q     <= n_d;
      z_q     <= z_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign C    = c_q;
  assign V    = v_q;
  assign N    = n_q;
  assign Z    = z_q;

endmodule

// File: tb/tb_add_sub_seq.sv
// Self-checking bench for add_sub_seq: vector table, hand-written handshake sequences and random ops vs. an arithmetic model.
module tb_add_sub_seq;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CHUNK = 8;
  localparam int NCH = WIDTH / CHUNK;

  logic clk = 1'b0;
  logic rst;
  logic start, op, cin;
  logic [WIDTH-1:0] a, b;
  logic busy, done;
  logic [WIDTH-1:0] sum;
  logic c_f, v_f, n_f, z_f;

  int checks = 0;
  int errors = 0;

  add_sub_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk),
    .rst(rst),
`ifdef ADD_SUB_SEQ_CIN_EN
    .cin(cin),
`endif
    .start(start),
    .op(op),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .sum(sum),
    .C(c_f),
    .V(v_f),
    .N(n_f),
    .Z(z_f)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        o;
    logic [31:0] x;
    logic [31:0] y;
    logic        ci;
    logic [31:0] s;
    logic        c, v, n, z;
  } vec_t;

  typedef struct {
    logic [31:0] s;
    logic        c, v, n, z;
  } res_t;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference: the arithmetic meaning of add/subtract with carry-in, in 64-bit integers
  function automatic res_t model(input logic o, input logic [31:0] x, input logic [31:0] y, input logic ci);
    res_t r;
    longint ux, uy, ur, sx, sy, sr;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!o) begin
      ur = ux + uy + longint'(ci);
      sr = sx + sy + longint'(ci);
      r.c = (ur >= 64'sh1_0000_0000);
    end else begin
      ur = ux - uy - 1 + longint'(ci);
      sr = sx - sy - 1 + longint'(ci);
      r.c = (ur >= 0);
    end
    r.s = ur[31:0];
    r.v = (sr > 64'sh7FFF_FFFF) || (sr < -64'sh8000_0000);
    r.n = r.s[31];
    r.z = (r.s == 32'h0);
    return r;
  endfunction

  function automatic logic eff_cin(input logic o, input logic ci);
`ifdef ADD_SUB_SEQ_CIN_EN
    return ci;
`else
    return o;
`endif
  endfunction

  // Drive a request on the falling edge; returns just after the accepting edge
  task automatic issue(input logic o, input logic [31:0] x, input logic [31:0] y, input logic ci);
    @(negedge clk);
    op = o; a = x; b = y; cin = ci; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = ~o; a = $urandom; b = $urandom; cin = ~ci;
  endtask

  // Steps edges until done, starting from cycle count cyc0; bounded
  task automatic wait_done(input int cyc0, output int cyc);
    cyc = cyc0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!done && cyc < 40);
    chk1("done_seen", done, 1'b1);
  endtask

  task automatic check_res(input string tag, input res_t e);
    chk32({tag, "_sum"}, sum, e.s);
    chk1({tag, "_C"}, c_f, e.c);
    chk1({tag, "_V"}, v_f, e.v);
    chk1({tag, "_N"}, n_f, e.n);
    chk1({tag, "_Z"}, z_f, e.z);
    chk1({tag, "_busy_low"}, busy, 1'b0);
  endtask

  task automatic run_op(input string tag, input logic o, input logic [31:0] x, input logic [31:0] y,
                        input logic ci, input res_t e);
    int cyc;
    issue(o, x, y, ci);
    chk1({tag, "_busy"}, busy, 1'b1);
    wait_done(0, cyc);
    chk32({tag, "_latency"}, 32'(cyc), 32'(NCH));
    check_res(tag, e);
  endtask

  task automatic check_all_zero(input string tag);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
    chk32({tag, "_sum"}, sum, 32'h0);
    chk1({tag, "_C"}, c_f, 1'b0);
    chk1({tag, "_V"}, v_f, 1'b0);
    chk1({tag, "_N"}, n_f, 1'b0);
    chk1({tag, "_Z"}, z_f, 1'b0);
  endtask

  initial begin
    vec_t tbl[$];
    res_t e;
    int cyc;
    int t_prev;
    int npulse;
    logic o, ci;
    logic [31:0] x, y;

    rst = 1'b1; start = 1'b0; op = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("post_reset");

    //         op    a             b             ci    sum           C     V     N     Z
    tbl.push_back('{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 32'h0000_0100, 32'h0000_0000, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0});
`ifdef ADD_SUB_SEQ_CIN_EN
    tbl.push_back('{1'b1, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 32'h0000_0001, 32'h0000_0001, 1'b1, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 32'h0000_0003, 32'h0000_0003, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0});
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      e.s = tbl[i].s; e.c = tbl[i].c; e.v = tbl[i].v; e.n = tbl[i].n; e.z = tbl[i].z;
      run_op($sformatf("vec%0d", i), tbl[i].o, tbl[i].x, tbl[i].y, tbl[i].ci, e);
    end

    // Mid-BUSY start is ignored; start in the DONE cycle is accepted directly
    issue(1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    @(posedge clk);
    #1;
    op = 1'b0; a = 32'h1; b = 32'h1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk1("ignored_busy", busy, 1'b1);
    wait_done(2, cyc);
    chk32("ignored_latency", 32'(cyc), 32'(NCH));
    chk32("ignored_sum", sum, 32'hFFFF_FFFF);
    op = 1'b0; a = 32'h1; b = 32'h1; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = 32'hDEAD_BEEF;
    chk1("done_accept_busy", busy, 1'b1);
    chk1("done_accept_pulse_end", done, 1'b0);
    chk32("sum_hold", sum, 32'hFFFF_FFFF);
    chk1("N_hold", n_f, 1'b1);
    wait_done(0, cyc);
    chk32("done_accept_latency", 32'(cyc), 32'(NCH));
    chk32("done_accept_sum", sum, 32'h0000_0002);
    @(posedge clk);
    #1;
    chk1("done_one_cycle", done, 1'b0);

    // Reset mid-operation aborts with no done pulse
    issue(1'b0, 32'h0F0F_0F0F, 32'h1111_1111, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    npulse = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) npulse++;
    end
    chk32("midrst_quiet", 32'(npulse), 32'h0);
    e = model(1'b1, 32'h0000_0010, 32'h0000_0020, eff_cin(1'b1, 1'b1));
    run_op("after_rst", 1'b1, 32'h0000_0010, 32'h0000_0020, 1'b1, e);

    // Held start: one op per NCH+1 cycles
    @(negedge clk);
    op = 1'b0; a = 32'h0000_0003; b = 32'h0000_0004; cin = 1'b0; start = 1'b1;
    t_prev = -1;
    npulse = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        if (t_prev < 0) chk32("held_first_lat", 32'(i), 32'(NCH));
        else chk32("held_period", 32'(i - t_prev), 32'(NCH + 1));
        chk32("held_sum", sum, 32'h0000_0007);
        t_prev = i;
        npulse++;
      end
    end
    start = 1'b0;
    chk1("held_pulses", npulse >= 2, 1'b1);
    repeat (NCH + 2) @(posedge clk);
    #1;

    // Random operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      o = 1'($urandom);
      ci = 1'($urandom);
      case ($urandom_range(0, 3))
        0: begin x = $urandom; y = $urandom; end
        1: begin x = 32'hFFFF_FFFF - $urandom_range(0, 3); y = $urandom_range(0, 3); end
        2: begin x = 32'h8000_0000 ^ $urandom_range(0, 1); y = 32'h7FFF_FFFF ^ $urandom_range(0, 1); end
        default: begin x = $urandom; y = x; end
      endcase
      e = model(o, x, y, eff_cin(o, ci));
      run_op($sformatf("rnd%0d", i), o, x, y, ci, e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/add_sub_seq.md
# add_sub_seq

Parametrised multi-cycle adder/subtractor with C/V/N/Z flags. It is the sequential successor of the team's combinational 32-bit add/sub block. The block processes a WIDTH-bit operand pair in CHUNK-bit slices, one slice per clock, chaining the carry through a register. This trades latency for a short carry path. It sits between the register-file read stage and the flag register, with a start/busy/done handshake toward the control unit.

## Interface
- WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits processed per cycle; NCH = WIDTH/CHUNK cycles per operation (CHUNK = WIDTH gives NCH = 1).

- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while busy = 0.
- op  input  1  0 = add, 1 = subtract; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while slices are being processed.
- done  output  1  one-cycle pulse when sum and flags are updated.
- sum  output  WIDTH  registered result.
- C  output  1  carry out of MSB; for subtract, 1 = no borrow.
- V  output  1  signed overflow.
- N  output  1  sum[WIDTH-1].
- Z  output  1  sum == 0.

## Operation
- Reset value of every output is 0: busy, done, sum, C, V, N, Z. The FSM resets to IDLE.
- FSM states:
  - IDLE: waiting for a request.
  - BUSY: processing slices.
  - DONE: one cycle, then returns to IDLE.
- Start acceptance:
  - Start is accepted in IDLE or DONE.
  - On acceptance, latch a, b_eff = op ? ~b : b, carry = op, slice counter = 0, zero accumulator = 1. Go to BUSY.
- Each BUSY edge, for slice i = counter:
  - {c_out, s_i} = a[i] + b_eff[i] + carry, all CHUNK-bit wide.
  - Store s_i into the internal result register.
  - carry <= c_out.
  - zero accumulator &= (s_i == 0).
  - counter++.
- At the edge that processes slice NCH-1:
  - Load sum from the full internal result register.
  - C = final carry.
  - N = result MSB.
  - Z = zero accumulator.
  - V = (a_msb == b_eff_msb) && (result_msb != a_msb).
  - Go to DONE.
- Outputs sum/C/V/N/Z change only on completion. They hold their values through subsequent BUSY periods until the next completion.
- start while busy = 1 is ignored. It is not queued and latched operands are unaffected.
- start asserted in DONE is accepted. DONE → BUSY directly, done still pulses for that cycle.
- Changes to a, b or op after acceptance have no effect.
- Reset mid-operation aborts immediately. All outputs go to 0 and no done pulse is produced.
- Arithmetic is modulo 2^WIDTH; no sign or zero extension inside the block.

## Timing
- If start is accepted at edge k:
  - busy = 1 from after edge k until edge k+NCH.
  - done = 1 for exactly the cycle following edge k+NCH.
  - sum and flags are valid from edge k+NCH onward.
- Latency is NCH cycles from the accepting edge to result.
- Throughput with start held high is one operation per NCH+1 cycles.
- NCH = 1 gives a 1-cycle busy and a 2-cycle period.
- The critical path is one CHUNK-bit adder plus the carry register.

## Configuration
- ADD_SUB_SEQ_CIN_EN: when defined, adds input port cin (1 bit), sampled with start.
  - Initial carry becomes cin instead of op.
  - Add computes a + b + cin; subtract computes a + ~b + cin (ARM-style ADC/SBC, cin = 1 means no borrow).
  - Flags are computed identically.
- When the macro is undefined, the cin port does not exist and initial carry = op.

## Test plan
WIDTH = 32, CHUNK = 8, NCH = 4, macro undefined unless stated.
- a = FFFF_FFFF, b = 0000_0001, op = 0 → after 4 cycles: done pulse, sum = 0000_0000, C = 1, Z = 1, V = 0, N = 0.
- a = 7FFF_FFFF, b = 0000_0001, op = 0 → sum = 8000_0000, V = 1, N = 1, C = 0, Z = 0.
- a = 0000_0000, b = 0000_0001, op = 1 → sum = FFFF_FFFF, C = 0, N = 1, V = 0, Z = 0.
- a = 8000_0000, b = 7FFF_FFFF, op = 0 → sum = FFFF_FFFF, C = 0, V = 0, N = 1.
  - Then pulse start again mid-BUSY with a = 1, b = 1: the pulse is ignored.
  - Then issue a = 1, b = 1 in the DONE cycle: sum = 0000_0002 with done exactly 4 cycles later.
- Start an operation, assert rst at cycle 2 → busy, done, sum and flags all read 0 immediately. After release, the FSM is in IDLE and no done appears.
- With ADD_SUB_SEQ_CIN_EN defined: a = 0000_0005, b = 0000_0003, op = 1, cin = 0 → sum = 0000_0001, C = 1; with cin = 1 → sum = 0000_0002.
